switch_debouncer: RTL and testbench

// - Conditions the 10 raw slide switches before they drive the LEDs or any downstream logic.
// - Per switch: a 2-flop synchronizer, then a stability counter. A new level is accepted only

---
 rtl/sw_cond_pkg.sv | 18 +
 rtl/debounce_bit.sv | 66 ++++++
 rtl/switch_debouncer.sv | 43 ++++
 tb/tb_switch_debouncer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sw_cond_pkg.sv
// Shared constants and helpers for the switch conditioning blocks.
package sw_cond_pkg;

   localparam int CLK_HZ                = 50_000_000;
   localparam int DEBOUNCE_MS           = 10;
   localparam int STABLE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;

   // Smallest width w with 2**w >= value (at least 1 so a counter always exists).
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer, stability counter,
// accepted level and registered rise/fall strobes.
module debounce_bit
   import sw_cond_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int CNT_W         = clog2(STABLE_CYCLES_DEFAULT)
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   output logic o_db,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_s1;
   logic             r_s2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_db;
   logic             r_rise;
   logic             r_fall;

   // Bring the asynchronous switch level into the clock domain; only r_s2 is used past here.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_sw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after it has disagreed with r_db for STABLE_CYCLES clocks in a row.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_db   <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_s2 == r_db) begin
            // Any return to the accepted level restarts the qualification window.
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db   <= r_s2;
            r_cnt  <= '0;
            r_rise <= r_s2;
            r_fall <= ~r_s2;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   assign o_db   = r_db;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide switch bank; one independent channel per switch
// plus a combined change indicator.
module switch_debouncer
   import sw_cond_pkg::*;
#(
   parameter int WIDTH         = 10,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int CNT_W         = clog2(STABLE_CYCLES_DEFAULT)
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] SW_DB,
   output logic [WIDTH-1:0] SW_RISE,
   output logic [WIDTH-1:0] SW_FALL,
   output logic             SW_CHANGED
);

   logic [WIDTH-1:0] w_db;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_bit (
         .i_clk   (CLOCK_50),
         .i_rst_n (RESET_N),
         .i_sw    (SW[gi]),
         .o_db    (w_db[gi]),
         .o_rise  (w_rise[gi]),
         .o_fall  (w_fall[gi])
      );
   end

   assign SW_DB      = w_db;
   assign SW_RISE    = w_rise;
   assign SW_FALL    = w_fall;
   // Strobes are already registered, so the combined flag lines up with them.
   assign SW_CHANGED = |{w_rise, w_fall};

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with a short qualification window.
module tb_switch_debouncer;

   localparam int W = 10;
   localparam int S = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] sw;
   logic [W-1:0] sw_db;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;

   int checks;
   int errors;

   switch_debouncer #(
      .WIDTH         (W),
      .STABLE_CYCLES (S),
      .CNT_W         (3)
   ) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .SW         (sw),
      .SW_DB      (sw_db),
      .SW_RISE    (sw_rise),
      .SW_FALL    (sw_fall),
      .SW_CHANGED (sw_changed)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Reference model: a bit's accepted level flips on edge n when the last S
   // synchronized samples (two-sample delay) all disagree with it, and all of
   // them were taken after that bit's last flip or reset.
   logic [W-1:0] m_db;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic [W-1:0] hist[$];
   logic [W-1:0] view[0:16383];
   int           last_evt[W];
   int           edge_n;

   task automatic model_edge(input logic r, input logic [W-1:0] s);
      logic [W-1:0] v;
      bit ok;
      edge_n++;
      m_rise = '0;
      m_fall = '0;
      if (!r) begin
         m_db = '0;
         hist = {};
         hist.push_back('0);
         hist.push_back('0);
         view[edge_n] = '0;
         for (int i = 0; i < W; i++) last_evt[i] = edge_n;
      end else begin
         v = hist.pop_front();
         hist.push_back(s);
         view[edge_n] = v;
         for (int i = 0; i < W; i++) begin
            if (edge_n - last_evt[i] >= S) begin
               ok = 1'b1;
               for (int j = 0; j < S; j++)
                  if (view[edge_n - j][i] == m_db[i]) ok = 1'b0;
               if (ok) begin
                  m_db[i]     = ~m_db[i];
                  m_rise[i]   = m_db[i];
                  m_fall[i]   = ~m_db[i];
                  last_evt[i] = edge_n;
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(rst_n, sw);
      #1;
      chk("model_db",   sw_db,   m_db);
      chk("model_rise", sw_rise, m_rise);
      chk("model_fall", sw_fall, m_fall);
      chk("model_chg",  {9'd0, sw_changed}, {9'd0, |{m_rise, m_fall}});
   endtask

   typedef struct {
      logic         rst_n;
      logic [W-1:0] sw;
      int           n;
      logic [W-1:0] db;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         chg;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [W-1:0] s, input int n,
                      input logic [W-1:0] db, input logic [W-1:0] rise,
                      input logic [W-1:0] fall, input logic chg);
      vec_t v;
      v.rst_n = r; v.sw = s; v.n = n;
      v.db = db; v.rise = rise; v.fall = fall; v.chg = chg;
      vecs.push_back(v);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      m_db   = '0;
      m_rise = '0;
      m_fall = '0;
      hist.push_back('0);
      hist.push_back('0);
      for (int i = 0; i < W; i++) last_evt[i] = 0;
      rst_n = 1'b0;
      sw    = '0;

      // reset with all switches up, then release
      add(0, 10'h3FF, 3, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h3FF, 5, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h3FF, 1, 10'h3FF, 10'h3FF, 10'h000, 1);
      add(1, 10'h3FF, 1, 10'h3FF, 10'h000, 10'h000, 0);
      // all down, then clean step on bit 0
      add(1, 10'h000, 5, 10'h3FF, 10'h000, 10'h000, 0);
      add(1, 10'h000, 1, 10'h000, 10'h000, 10'h3FF, 1);
      add(1, 10'h001, 5, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h001, 1, 10'h001, 10'h001, 10'h000, 1);
      add(1, 10'h001, 1, 10'h001, 10'h000, 10'h000, 0);
      // bounce on bit 3
      add(1, 10'h009, 2, 10'h001, 10'h000, 10'h000, 0);
      add(1, 10'h001, 2, 10'h001, 10'h000, 10'h000, 0);
      add(1, 10'h009, 2, 10'h001, 10'h000, 10'h000, 0);
      add(1, 10'h001, 2, 10'h001, 10'h000, 10'h000, 0);
      add(1, 10'h009, 5, 10'h001, 10'h000, 10'h000, 0);
      add(1, 10'h009, 1, 10'h009, 10'h008, 10'h000, 1);
      // 3-clock glitch on bit 5
      add(1, 10'h029, 3, 10'h009, 10'h000, 10'h000, 0);
      add(1, 10'h009, 6, 10'h009, 10'h000, 10'h000, 0);
      // back to zero, then simultaneous rise and fall of 0x2A5
      add(1, 10'h000, 6, 10'h000, 10'h000, 10'h009, 1);
      add(1, 10'h2A5, 5, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h2A5, 1, 10'h2A5, 10'h2A5, 10'h000, 1);
      add(1, 10'h000, 5, 10'h2A5, 10'h000, 10'h000, 0);
      add(1, 10'h000, 1, 10'h000, 10'h000, 10'h2A5, 1);
      // reset in the middle of counting a rise on bit 9
      add(1, 10'h200, 4, 10'h000, 10'h000, 10'h000, 0);
      add(0, 10'h200, 1, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h200, 5, 10'h000, 10'h000, 10'h000, 0);
      add(1, 10'h200, 1, 10'h200, 10'h200, 10'h000, 1);

      foreach (vecs[k]) begin
         rst_n = vecs[k].rst_n;
         sw    = vecs[k].sw;
         for (int c = 0; c < vecs[k].n; c++) tick();
         chk($sformatf("vec%0d_db", k),   sw_db,   vecs[k].db);
         chk($sformatf("vec%0d_rise", k), sw_rise, vecs[k].rise);
         chk($sformatf("vec%0d_fall", k), sw_fall, vecs[k].fall);
         chk($sformatf("vec%0d_chg", k),  {9'd0, sw_changed}, {9'd0, vecs[k].chg});
      end

      // randomized bouncing with occasional resets
      for (int t = 0; t < 3000; t++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 7) == 0) sw[i] = ~sw[i];
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
